// File: rtl/float_writeback_arbiter.sv
// FP register-file write arbiter with pending-write scoreboard.
// Define FLOAT_WB_RR_EN for round-robin; default is fixed priority A > B.
module float_writeback_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  issue_valid_i,
    input  logic [4:0]            issue_rd_i,
    input  logic                  a_valid_i,
    output logic                  a_ready_o,
    input  logic [4:0]            a_rd_i,
    input  logic [DATA_WIDTH-1:0] a_data_i,
    input  logic                  b_valid_i,
    output logic                  b_ready_o,
    input  logic [4:0]            b_rd_i,
    input  logic [DATA_WIDTH-1:0] b_data_i,
    output logic                  reg_write_o,
    output logic [4:0]            rd_o,
    output logic [DATA_WIDTH-1:0] write_data_o,
    output logic [31:0]           pending_o,
    output logic                  busy_o
);

    logic                  a_win;
    logic                  xfer;
    logic                  wr_en;
    logic [4:0]            sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;

    logic                  reg_write_q;
    logic [4:0]            rd_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [31:0]           pending_q;
    logic [31:0]           pending_d;
    logic                  busy_q;

`ifdef FLOAT_WB_RR_EN
    // Pointer: 1 means B was granted last, so A wins the next contention.
    logic last_b_q;

    assign a_win = last_b_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_b_q <= 1'b1;
        end else if (xfer) begin
            last_b_q <= b_ready_o;
        end
    end
`else
    assign a_win = 1'b1;
`endif

    assign a_ready_o = a_valid_i & (~b_valid_i | a_win);
    assign b_ready_o = b_valid_i & ~(a_valid_i & a_win);
    assign xfer      = a_ready_o | b_ready_o;
    assign sel_rd    = a_ready_o ? a_rd_i : b_rd_i;
    assign sel_data  = a_ready_o ? a_data_i : b_data_i;
    assign wr_en     = xfer & (sel_rd != 5'd0);

    // Set is applied after clear so a same-cycle issue keeps the bit.
    always_comb begin
        pending_d = pending_q;
        if (wr_en) begin
            pending_d[sel_rd] = 1'b0;
        end
        if (issue_valid_i && (issue_rd_i != 5'd0)) begin
            pending_d[issue_rd_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            reg_write_q <= 1'b0;
            rd_q        <= 5'd0;
            data_q      <= '0;
            pending_q   <= 32'd0;
            busy_q      <= 1'b0;
        end else begin
            reg_write_q <= wr_en;
            if (wr_en) begin
                rd_q   <= sel_rd;
                data_q <= sel_data;
            end
            pending_q <= pending_d;
            busy_q    <= |pending_d;
        end
    end

    assign reg_write_o  = reg_write_q;
    assign rd_o         = rd_q;
    assign write_data_o = data_q;
    assign pending_o    = pending_q;
    assign busy_o       = busy_q;

endmodule

// File: doc/float_writeback_arbiter.md
# float_writeback_arbiter

Write-side companion of the floating-point register file. It accepts results from two FP producers over valid/ready handshakes and arbitrates between them. It drives the register file's single write port (write enable, destination, data) from a registered stage. It also keeps a 32-bit pending-write scoreboard that decode uses to detect RAW/WAW hazards on float registers.

## Interface
- DATA_WIDTH, 32, width of result data and write_data_o

- clk_i  input  1  clock, all state on rising edge
- rst_i  input  1  reset, asynchronous, active-high
- issue_valid_i  input  1  an FP instruction with float destination is issued this cycle
- issue_rd_i  input  5  destination of the issued instruction
- a_valid_i  input  1  producer A (FPU) result valid
- a_ready_o  output  1  producer A result accepted this cycle
- a_rd_i  input  5  producer A destination
- a_data_i  input  DATA_WIDTH  producer A result
- b_valid_i  input  1  producer B (FP load) result valid
- b_ready_o  output  1  producer B result accepted this cycle
- b_rd_i  input  5  producer B destination
- b_data_i  input  DATA_WIDTH  producer B result
- reg_write_o  output  1  register file write enable
- rd_o  output  5  register file write address
- write_data_o  output  DATA_WIDTH  register file write data
- pending_o  output  32  bit n = 1 while fn has an outstanding write
- busy_o  output  1  OR-reduction of pending_o

## Operation
- Handshake: a transfer occurs on a rising edge when valid and ready are both high. Producers hold valid/rd/data stable until accepted. ready_o is combinational from the valid inputs and arbitration state, never from ready.
- At most one transfer per cycle. The register file never stalls, so the sole valid requester is always granted.
- Contention (both valid): the arbitration policy applies (see Configuration); the loser's ready_o stays 0.
- Output stage: an accepted result loads reg_write_o=1, rd_o, write_data_o on the next edge. With no transfer, reg_write_o=0 and rd_o/write_data_o hold their values.
- rd = 0: the transfer is accepted (ready asserted), but reg_write_o stays 0 and no scoreboard bit changes.
- Scoreboard, per edge:
  - issue_valid_i with issue_rd_i≠0 sets that bit.
  - An accepted transfer clears the bit of its rd.
  - If both hit the same register in one cycle, set wins.
  - Issuing to an already-pending register leaves it at 1; there is no counting, and decode guarantees a single outstanding writer.
- pending_o and busy_o are registered.

## Timing
- Reset values: reg_write_o=0, rd_o=0, write_data_o=0, pending_o=0, busy_o=0, arbitration pointer = "B granted last".
- Latency: handshake edge → reg_write_o high for exactly one cycle after that edge. The register file captures the data on the following edge. The pending bit clears on the same edge reg_write_o rises.
- Back-to-back transfers produce consecutive reg_write_o pulses with no bubble.
- Reset asserted mid-operation clears all outputs and the scoreboard immediately, independent of clk_i. The in-flight write is dropped. Deassertion takes effect at the next rising edge.

## Configuration
- FLOAT_WB_RR_EN defined: round-robin arbitration.
  - The pointer records the last granted port, updated on every transfer.
  - On contention, the port not granted last wins.
- FLOAT_WB_RR_EN undefined: fixed priority, A always beats B. No pointer flop exists, and B can starve under continuous A traffic.

## Test plan
- After reset: all outputs 0. A valid with rd=5, data=0x3F800000 → a_ready_o=1; next cycle reg_write_o=1, rd_o=5, write_data_o=0x3F800000; following cycle reg_write_o=0.
- issue rd=7; three cycles later B returns rd=7 → pending_o[7]=1 and busy_o=1 until the write cycle, then 0.
- Same cycle: issue rd=3 and A writes rd=3 → pending_o[3] remains 1.
- A and B both valid for 4 cycles (rd 1..4 vs 9..12):
  - RR build grants A,B,A,B with writes in that order.
  - Fixed-priority build grants A four times with b_ready_o=0 throughout.
- A valid with rd=0 → a_ready_o=1, reg_write_o never rises, pending_o unchanged.
- Assert rst_i asynchronously between clock edges while reg_write_o=1 and pending_o≠0 → outputs 0 before the next edge; no write after deassertion.
